// File: rtl/mux_pkg.sv
// Shared constants for the 16:1 selector and its 4:1 leaf cells.
package mux_pkg;

    localparam int   N_INPUTS   = 16;
    localparam int   SEL_W      = 4;
    localparam logic RST_VAL    = 1'b0;

    localparam int   LEAF_W     = 4;
    localparam int   LEAF_SEL_W = 2;
    localparam int   N_LEAVES   = N_INPUTS / LEAF_W;

endpackage : mux_pkg

// File: rtl/mux4to1.sv
// Purely combinational 4:1 single-bit selector used as the tree building block.
module mux4to1
    import mux_pkg::*;
(
    input  logic [LEAF_W-1:0]     d,
    input  logic [LEAF_SEL_W-1:0] s,
    output logic                  y
);

    // Two levels of 2:1 ternaries; an X/Z select bit propagates X instead of a forced value.
    assign y = s[1] ? (s[0] ? d[3] : d[2])
                    : (s[0] ? d[1] : d[0]);

endmodule : mux4to1

// File: rtl/mux16to1.sv
// 16:1 single-bit selector built from a two-level 4:1 tree, with an optional output flop.
module mux16to1
    import mux_pkg::*;
#(
    parameter int REG_OUT = 1
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SEL_W-1:0]    s,
    input  logic [N_INPUTS-1:0] d,
    output logic                y
);

    logic [N_LEAVES-1:0] stage1_s;
    logic                sel_bit_s;

    // First stage: leaf k resolves d[4k+3:4k] with the low select bits.
    for (genvar k = 0; k < N_LEAVES; k++) begin : g_leaf
        mux4to1 u_leaf (
            .d (d[LEAF_W*k +: LEAF_W]),
            .s (s[LEAF_SEL_W-1:0]),
            .y (stage1_s[k])
        );
    end

    mux4to1 u_root (
        .d (stage1_s),
        .s (s[SEL_W-1:LEAF_SEL_W]),
        .y (sel_bit_s)
    );

    if (REG_OUT != 0) begin : g_reg
        logic y_r;

        // Output flop: loads the selected bit every edge, cleared asynchronously by reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y_r <= RST_VAL;
            end else begin
                y_r <= sel_bit_s;
            end
        end

        assign y = y_r;
    end else begin : g_comb
        logic unused_s;
        assign unused_s = clk ^ rst_n;
        assign y        = sel_bit_s;
    end

endmodule : mux16to1

// File: tb/tb_mux16to1.sv
// Self-checking bench for mux16to1: registered and combinational builds side by side.
module tb_mux16to1;
    import mux_pkg::*;

    typedef struct {
        logic [3:0]  s;
        logic [15:0] d;
        logic        exp;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst_c_n;
    logic [3:0]  s;
    logic [15:0] d;
    logic        y;
    logic        y_c;

    int checks   = 0;
    int failures = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mux16to1 #(.REG_OUT(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s),
        .d     (d),
        .y     (y)
    );

    mux16to1 #(.REG_OUT(0)) u_comb (
        .clk   (clk),
        .rst_n (rst_c_n),
        .s     (s),
        .d     (d),
        .y     (y_c)
    );

    // Reference: the selected bit is bit s of d, computed by shifting.
    function automatic logic ref_sel(input logic [3:0] sel, input logic [15:0] data);
        logic [15:0] shifted;
        shifted = data >> sel;
        return shifted[0];
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b (t=%0t s=%0h d=%04h)", name, act, exp, $time, s, d);
        end
    endtask

    // Drive one setting mid-cycle, check the hold/comb behaviour, then the loaded value after the edge.
    task automatic apply(input string name, input logic [3:0] sv, input logic [15:0] dv,
                         input logic exp, inout logic prev_exp);
        s = sv;
        d = dv;
        #1;
        check({name, "_comb"}, y_c, exp);
        check({name, "_hold"}, y, prev_exp);
        @(posedge clk);
        #1;
        check({name, "_reg"}, y, exp);
        prev_exp = exp;
    endtask

    initial begin
        logic        prev;
        logic [15:0] rd;
        logic [3:0]  rs;
        logic [15:0] one16;

        one16   = 16'h0001;
        rst_n   = 1'b0;
        rst_c_n = 1'b1;
        s       = 4'h0;
        d       = 16'hFFFF;

        // Reset state, before and across a clock edge.
        #1;
        check("reset_initial", y, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", y, 1'b0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_after_release", y, 1'b1);
        prev = 1'b1;

        // Stimulus table: walking one, walking zero, select-only sweep over 16'hAAAA.
        for (int i = 0; i < 16; i++) vecs.push_back('{4'(i), one16 << i, 1'b1, "walk1"});
        for (int i = 0; i < 16; i++) vecs.push_back('{4'(i), ~(one16 << i), 1'b0, "walk0"});
        for (int i = 0; i < 16; i++) vecs.push_back('{4'(i), 16'hAAAA, (i % 2 == 1) ? 1'b1 : 1'b0, "aaaa"});
        vecs.push_back('{4'hA, 16'hFBFF, 1'b0, "walk0_a"});

        foreach (vecs[i]) apply(vecs[i].name, vecs[i].s, vecs[i].d, vecs[i].exp, prev);

        // Isolation: d[5] held high, every other bit randomised.
        for (int i = 0; i < 20; i++) begin
            rd = 16'($urandom) | 16'h0020;
            apply("isolation", 4'h5, rd, 1'b1, prev);
        end

        // Randomised select and data against the shift model.
        for (int i = 0; i < 200; i++) begin
            rs = 4'($urandom_range(0, 15));
            rd = 16'($urandom);
            apply("random", rs, rd, ref_sel(rs, rd), prev);
        end

        // Asynchronous reset mid-cycle, held across an edge, then released.
        apply("pre_reset", 4'hF, 16'h8000, 1'b1, prev);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", y, 1'b0);
        @(posedge clk);
        #1;
        check("async_reset_held", y, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        check("release_no_edge", y, 1'b0);
        @(posedge clk);
        #1;
        check("release_first_edge", y, 1'b1);

        // Combinational build ignores reset and needs no edge.
        rst_c_n = 1'b0;
        s       = 4'h3;
        d       = 16'h0008;
        #1;
        check("comb_sel3", y_c, 1'b1);
        d = 16'hFFF7;
        #1;
        check("comb_sel3_zero", y_c, 1'b0);
        rst_c_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux16to1

// File: doc/mux16to1.md
# mux16to1

Single-bit 16:1 selector with a registered output. It picks one of 16 data lines using a 4-bit binary select and presents the chosen bit on `y` one clock after sampling. It is a leaf datapath primitive for control/status fan-in paths where a clean, glitch-free flop output is required.

## Interface
Parameters:
- `REG_OUT`, default 1: 1 gives a registered output with 1-cycle latency; 0 gives a purely combinational `y`, and `clk`/`rst_n` are then unused.

Ports:
- `clk`  input  1  rising-edge clock; the design has exactly one clock.
- `rst_n`  input  1  reset, asynchronous and active-low. Assertion clears `y` immediately. Deassertion is synchronized externally.
- `s`  input  4  binary select, unsigned 0..15.
- `d`  input  16  data lines; `d[i]` is input channel i.
- `y`  output  1  selected bit, `d[s]`.

## Operation
- Combinational select: `sel_bit = d[s]`, for all 16 values of `s`. There is no default or don't-care lane, and no one-hot decoding of `s`.
- Bit ordering: `s = 0` selects `d[0]` (LSB) and `s = 15` selects `d[15]` (MSB).
- With `REG_OUT = 1`:
  - `y` is a flop that loads `sel_bit` on every rising `clk`.
  - There is no enable and no hold state.
- With `REG_OUT = 0`:
  - `y = sel_bit` directly.
  - There is no storage.
- Reset:
  - `rst_n = 0` forces `y = 0` asynchronously, independent of `clk`, `s` and `d`.
  - `y` stays 0 while reset is held.
  - The first rising edge after `rst_n` rises loads `d[s]`.
- Unknown select: if any bit of `s` is X/Z in simulation, the selected value may be X. RTL must not mask this to 0, so that connectivity errors stay visible.
- Non-selected `d` bits never affect `y`. A toggle on `d[j]` with `j != s` must produce no change and no glitch on registered `y`.

## Timing
- `REG_OUT = 1`: latency is exactly 1 cycle. The `s`/`d` values sampled at edge N appear on `y` after edge N and hold until edge N+1.
- `REG_OUT = 0`: zero latency; the path from `s`/`d` to `y` is combinational only.
- Simultaneous change of `s` and `d` before an edge: the edge captures the new `d` indexed by the new `s`.
- Reset asserted mid-operation: `y` goes to 0 within the same cycle without waiting for a clock edge. Any in-flight sample is discarded.
- Reset released and clock edge at the same time: treated as still in reset, so `y` = 0 until the following edge.
- Critical path: a 2-level 4:1 tree, i.e. `s` to 2 mux levels to the flop D input.

## Structure
- Shared package `mux_pkg` holds:
  - `N_INPUTS = 16`
  - `SEL_W = 4`
  - `RST_VAL = 1'b0`
- Sub-module `mux4to1`: inputs 4-bit `d` and 2-bit `s`, output 1-bit `y`, purely combinational.
- The top instantiates 5 of them:
  - Four first-stage instances take `d[4k+3:4k]` with `s[1:0]`, for k = 0..3.
  - One second-stage instance takes those four outputs with `s[3:2]`.
- The top adds the output flop and the `REG_OUT` generate branch.

## Test plan
- Walking-one sweep: for `s` = 0..15 set `d = 1 << s`, i.e. `16'h0001`, `16'h0002`, …, `16'h8000`, one setting per cycle -> `y = 1` one cycle later for each step.
- Walking-zero sweep: for each `s`, `d = ~(1 << s)`, e.g. `s = 4'hA`, `d = 16'hFBFF` -> `y = 0`. Any off-by-one or bit-reversal shows as 1.
- Isolation: `s = 4'h5`, `d[5] = 1` held, other bits toggled randomly for 20 cycles -> `y` stays constantly 1.
- Async reset: `s = 4'hF`, `d = 16'h8000`, `y = 1`; drop `rst_n` mid-cycle -> `y = 0` before the next edge. Release `rst_n` -> `y = 1` after the first following edge.
- Select change only: `d = 16'hAAAA`, step `s` through 0..15 -> `y` sequence is 0,1,0,1,… with 1-cycle lag.
- Combinational build (`REG_OUT = 0`): `s = 4'h3`, `d = 16'h0008` -> `y = 1` with no clock edge; `rst_n` has no effect.
